// File: rtl/mod_run_controller_pkg.sv
// mod_run_controller_pkg: state encoding and fixed timing constants for the run controller
package mod_run_controller_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_CPU = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP_EXEC = 3'd4,
    S_DRAIN     = 3'd5,
    S_DUMP      = 3'd6,
    S_DONE      = 3'd7
  } state_t;
  localparam int RESET_LEN = 2;
endpackage

// File: rtl/mod_sat_counter.sv
// mod_sat_counter: up-counter with synchronous clear that sticks at all-ones
// ports: clk, rst (sync, active-high), clr_i (priority clear), inc_i, cnt_o
module mod_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mod_run_controller.sv
// mod_run_controller: sequences core reset, free-run/single-step, end detection, drain and dump
// inputs:  clk, reset (sync, active-high), start, step_en, step, mem_end, pc
// outputs: cpu_reset, hold, dump_all, busy, done, timeout, cycle_count, instr_count, end_pc
module mod_run_controller
  import mod_run_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_INSTRS = 65535,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_en,
  input  logic             step,
  input  logic             mem_end,
  input  logic [31:0]      pc,
  output logic             cpu_reset,
  output logic             hold,
  output logic             dump_all,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [31:0]      end_pc
);
  // one down-counter times both the core-reset window and the drain window
  localparam int DW = $clog2(DRAIN_CYCLES + RESET_LEN);
  state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic [31:0] end_pc_q, end_pc_d;
  logic [CNT_W-1:0] instr_next;
  logic exec, retire, wd_hit, clr;
  assign exec = state_q == S_RUN || state_q == S_STEP_EXEC;
  // an instruction only commits when the fetch is not past the program end
  assign retire = exec && !mem_end;
  assign instr_next = instr_count + 1'b1;
  assign wd_hit = TIMEOUT_INSTRS != 0 && instr_next == CNT_W'(TIMEOUT_INSTRS);
  assign clr = (state_q == S_IDLE || state_q == S_DONE) && start;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    timeout_d = timeout_q;
    end_pc_d = end_pc_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_RESET_CPU;
        cnt_d = DW'(RESET_LEN - 1);
        timeout_d = 1'b0;
      end
      S_RESET_CPU: if (cnt_q == '0) state_d = step_en ? S_STEP_WAIT : S_RUN;
        else cnt_d = cnt_q - 1'b1;
      S_RUN, S_STEP_EXEC: if (mem_end || wd_hit) begin
        state_d = S_DRAIN;
        cnt_d = DW'(DRAIN_CYCLES - 1);
        end_pc_d = pc;
        timeout_d = !mem_end;
      end else if (step_en || state_q == S_STEP_EXEC) state_d = S_STEP_WAIT;
      S_STEP_WAIT: if (mem_end) begin
        state_d = S_DRAIN;
        cnt_d = DW'(DRAIN_CYCLES - 1);
        end_pc_d = pc;
      end else if (step) state_d = S_STEP_EXEC;
      else if (!step_en) state_d = S_RUN;
      S_DRAIN: if (cnt_q == '0) state_d = S_DUMP;
        else cnt_d = cnt_q - 1'b1;
      S_DUMP: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      timeout_q <= 1'b0;
      end_pc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
      end_pc_q <= end_pc_d;
    end
  end
  assign cpu_reset = state_q == S_IDLE || state_q == S_RESET_CPU;
  assign hold = !retire;
  assign dump_all = state_q == S_DUMP;
  assign busy = !(state_q == S_IDLE || state_q == S_DONE);
  assign done = state_q == S_DONE;
  assign timeout = timeout_q;
  assign end_pc = end_pc_q;
  mod_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(reset), .clr_i(clr), .inc_i(busy), .cnt_o(cycle_count)
  );
  mod_sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk(clk), .rst(reset), .clr_i(clr), .inc_i(retire), .cnt_o(instr_count)
  );
endmodule
